// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one word fetch at a time against instruction memory,
// hands instruction + PC+4 to decode, and redirects on a taken branch while squashing wrong-path data.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic        br_n,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    input  logic        id_ready
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic            drop, drop_d;
    logic            if_valid_d;
    logic [XLEN-1:0] if_instr_d, if_pc4_d;
    logic            redirect;
    logic [XLEN-1:0] target;

    // br_n is active-low: 0 means the branch is taken
    assign redirect = br_valid & ~br_n;
    assign target   = br_pc4 + {br_offset[XLEN-3:0], 2'b00};

    // Request is only a function of state, but must be masked while reset is asserted
    assign imem_req  = ~rst & (state == S_REQ);
    assign imem_addr = pc;

    // Next-state and datapath updates
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        drop_d     = drop;
        if_valid_d = if_valid;
        if_instr_d = if_instr;
        if_pc4_d   = if_pc4;

        case (state)
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    pc_d    = redirect ? target : pc + XLEN'(4);
                    drop_d  = redirect;
                end else if (redirect) begin
                    pc_d = target;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc4_d   = pc;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A taken branch wins over decode accepting the held instruction
                if (redirect) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d    = S_REQ;
                drop_d     = 1'b0;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc4   <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            drop     <= drop_d;
            if_valid <= if_valid_d;
            if_instr <= if_instr_d;
            if_pc4   <= if_pc4_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances with different reset PCs share one stimulus stream and are
// checked every cycle against a transaction-level model, plus directed literal expectations.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_n;
    logic [31:0] br_pc4, br_offset;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_ready;

    logic        req0, req1, val0, val1;
    logic [31:0] addr0, addr1, instr0, instr1, pc40, pc41;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] RP0 = 32'h0040_0000;
    localparam logic [31:0] RP1 = 32'hFFFF_FFFC;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RP0)) u_dut0 (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_n(br_n), .br_pc4(br_pc4),
        .br_offset(br_offset), .imem_req(req0), .imem_addr(addr0), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(val0),
        .if_instr(instr0), .if_pc4(pc40), .id_ready(id_ready)
    );

    pc_fetch_unit #(.RESET_PC(RP1)) u_dut1 (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_n(br_n), .br_pc4(br_pc4),
        .br_offset(br_offset), .imem_req(req1), .imem_addr(addr1), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(val1),
        .if_instr(instr1), .if_pc4(pc41), .id_ready(id_ready)
    );

    // Transaction-level model: a fetch is either being asked for, outstanding, or parked for decode
    logic [31:0] m_pc [2];
    logic [31:0] m_pc4 [2];
    logic [31:0] m_instr;
    bit          m_busy, m_drop, m_held, m_live;

    always @(posedge clk) begin
        logic        taken;
        logic [31:0] tgt;
        taken = br_valid && !br_n;
        tgt   = br_pc4 + (br_offset << 2);
        if (rst) begin
            m_pc[0] = RP0; m_pc[1] = RP1; m_pc4[0] = 0; m_pc4[1] = 0;
            m_instr = 0; m_busy = 0; m_drop = 0; m_held = 0; m_live = 1;
        end else if (m_live) begin
            if (!m_busy && !m_held) begin
                if (imem_gnt) begin
                    m_busy = 1;
                    m_drop = taken;
                    for (int i = 0; i < 2; i++) m_pc[i] = taken ? tgt : m_pc[i] + 4;
                end else if (taken) begin
                    for (int i = 0; i < 2; i++) m_pc[i] = tgt;
                end
            end else if (m_busy) begin
                if (taken) begin
                    for (int i = 0; i < 2; i++) m_pc[i] = tgt;
                    if (imem_rvalid) begin m_busy = 0; m_drop = 0; end
                    else m_drop = 1;
                end else if (imem_rvalid) begin
                    m_busy = 0;
                    if (!m_drop) begin
                        m_held = 1; m_instr = imem_rdata;
                        for (int i = 0; i < 2; i++) m_pc4[i] = m_pc[i];
                    end
                    m_drop = 0;
                end
            end else begin
                if (taken) begin
                    m_held = 0;
                    for (int i = 0; i < 2; i++) m_pc[i] = tgt;
                end else if (id_ready) begin
                    m_held = 0;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            logic exp_req;
            exp_req = !rst && !m_busy && !m_held;
            cmp("req0", 32'(req0), 32'(exp_req));
            cmp("req1", 32'(req1), 32'(exp_req));
            cmp("addr0", addr0, m_pc[0]);
            cmp("addr1", addr1, m_pc[1]);
            cmp("valid0", 32'(val0), 32'(m_held));
            cmp("valid1", 32'(val1), 32'(m_held));
            cmp("instr0", instr0, m_instr);
            cmp("instr1", instr1, m_instr);
            cmp("pc4_0", pc40, m_pc4[0]);
            cmp("pc4_1", pc41, m_pc4[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        br_valid = 0; br_n = 1; imem_gnt = 0; imem_rvalid = 0; id_ready = 0;
    endtask

    task automatic fetch(input logic [31:0] data);
        imem_gnt = 1; tick(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = data; tick(); imem_rvalid = 0;
    endtask

    initial begin
        rst = 1; br_pc4 = 0; br_offset = 0; imem_rdata = 0;
        idle();
        tick(); tick();
        cmp("lit_rst_addr", addr0, 32'h0040_0000);
        cmp("lit_rst_req", 32'(req0), 32'd0);
        cmp("lit_rst_valid", 32'(val0), 32'd0);

        // First fetch
        rst = 0; tick();
        cmp("lit_req_on", 32'(req0), 32'd1);
        cmp("lit_first_addr", addr0, 32'h0040_0000);
        fetch(32'h8C08_0004);
        cmp("lit_valid", 32'(val0), 32'd1);
        cmp("lit_instr", instr0, 32'h8C08_0004);
        cmp("lit_pc4", pc40, 32'h0040_0004);
        cmp("lit_wrap_pc4", pc41, 32'h0000_0000);

        // Decode stalls for five cycles
        for (int k = 0; k < 5; k++) begin
            tick();
            cmp("lit_stall_valid", 32'(val0), 32'd1);
            cmp("lit_stall_req", 32'(req0), 32'd0);
            cmp("lit_stall_instr", instr0, 32'h8C08_0004);
        end
        id_ready = 1; tick(); id_ready = 0;
        cmp("lit_accept_valid", 32'(val0), 32'd0);
        cmp("lit_next_addr", addr0, 32'h0040_0004);
        cmp("lit_wrap_addr", addr1, 32'h0000_0000);

        // Taken branch in HOLD: 0x400010 + (-4 words) = 0x400000
        fetch(32'h0000_0020);
        br_valid = 1; br_n = 0; br_pc4 = 32'h0040_0010; br_offset = 32'hFFFF_FFFC;
        tick(); idle();
        cmp("lit_redir_valid", 32'(val0), 32'd0);
        cmp("lit_redir_addr", addr0, 32'h0040_0000);

        // Not-taken branch in HOLD leaves the flow alone
        fetch(32'h2402_0001);
        br_valid = 1; br_n = 1;
        tick(); idle();
        cmp("lit_nt_valid", 32'(val0), 32'd1);
        id_ready = 1; tick(); idle();
        cmp("lit_nt_addr", addr0, 32'h0040_0004);

        // Taken branch while fetch outstanding, data arrives later and is dropped
        imem_gnt = 1; tick(); idle();
        br_valid = 1; br_n = 0; br_pc4 = 32'h0040_0000; br_offset = 32'h0000_0040;
        tick(); idle();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick(); idle();
        cmp("lit_drop_valid", 32'(val0), 32'd0);
        cmp("lit_drop_addr", addr0, 32'h0040_0100);

        // Taken branch coincident with grant, then stray rvalid while requesting
        imem_gnt = 1; br_valid = 1; br_n = 0; br_pc4 = 32'h0040_0200; br_offset = 0;
        tick(); idle();
        cmp("lit_gnt_redir_addr", addr0, 32'h0040_0200);
        imem_rvalid = 1; imem_rdata = 32'h1234_5678; tick(); idle();
        cmp("lit_gnt_drop_valid", 32'(val0), 32'd0);
        imem_rvalid = 1; tick(); idle();
        cmp("lit_stray_valid", 32'(val0), 32'd0);

        // Taken branch in REQ without grant, then redirect and rvalid in the same WAIT cycle
        br_valid = 1; br_n = 0; br_pc4 = 32'h0040_0300; br_offset = 32'h0000_0001;
        tick(); idle();
        cmp("lit_req_redir_addr", addr0, 32'h0040_0304);
        imem_gnt = 1; tick(); idle();
        imem_rvalid = 1; br_valid = 1; br_n = 0; br_pc4 = 32'h0040_0400; br_offset = 0;
        tick(); idle();
        cmp("lit_wait_both_valid", 32'(val0), 32'd0);
        cmp("lit_wait_both_addr", addr0, 32'h0040_0400);
        fetch(32'h0000_0001);
        id_ready = 1; tick(); idle();

        // Reset while holding an instruction
        fetch(32'h0000_0002);
        rst = 1; tick(); rst = 0;
        cmp("lit_rst_hold_valid", 32'(val0), 32'd0);
        cmp("lit_rst_hold_addr0", addr0, RP0);
        cmp("lit_rst_hold_addr1", addr1, RP1);
        tick();
        fetch(32'h0000_0003);
        cmp("lit_wrap2_pc4", pc41, 32'h0000_0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
